// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the EX-stage multiply unit and its decode neighbours.
//   FUNCT_*    : R-type funct codes handled by / around the multiplier
//   MUL_CYCLES : iteration count of the shift-add multiplier (one per bit)
//   mul_state_t: FSM encoding (ST_IDLE / ST_RUN / ST_DONE)
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;

    localparam int MUL_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/multu_unit_mul_step.sv
// ---------------------------------------------------------------------------
// mul_step
// One combinational iteration of the shift-add multiplier.
//   acc         : running upper partial product
//   mcand       : multiplicand
//   mplier      : remaining multiplier bits (low bits collect the product)
//   next_acc    : acc after conditional add and right shift
//   next_mplier : mplier after right shift, carrying in the sum's LSB
// The add is WIDTH+1 bits wide so the carry is shifted into acc's MSB.
// ---------------------------------------------------------------------------
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] next_acc,
    output logic [WIDTH-1:0] next_mplier
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc};
        if (mplier[0]) begin
            sum = {1'b0, acc} + {1'b0, mcand};
        end
        next_acc    = sum[WIDTH:1];
        next_mplier = {sum[0], mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_unit.sv
// ---------------------------------------------------------------------------
// multu_unit
// EX-stage multi-cycle shift-add multiplier writing HI/LO.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : one-cycle issue strobe, accepted only in IDLE
//   is_signed : (MULTU_SIGNED_EN only) treat operands as two's complement
//   op_a/op_b : multiplicand / multiplier
//   busy      : high for the WIDTH iteration cycles
//   done      : one-cycle pulse, HI/LO valid from this cycle
//   stall_req : start | busy, freezes fetch from the issue cycle onward
//   hi/lo     : product words, held between operations
// Build option: define MULTU_SIGNED_EN to add the is_signed port (MULT).
// ---------------------------------------------------------------------------
module multu_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MUL_CYCLES,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef MULTU_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mul_state_t state, state_nx;

    logic [WIDTH-1:0]   acc, mcand, mplier;
    logic [WIDTH-1:0]   next_acc, next_mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fin;

`ifdef MULTU_SIGNED_EN
    logic neg;
    logic neg_in;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic en);
        logic signed [WIDTH-1:0] s;
        s = v;
        return (en && s < 0) ? WIDTH'(-s) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_negate(input logic [2*WIDTH-1:0] v,
                                                       input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    // Magnitudes are taken at issue; the sign is reapplied on the last step.
    always_comb begin
        a_mag    = magnitude(op_a, is_signed);
        b_mag    = magnitude(op_b, is_signed);
        neg_in   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        prod_fin = cond_negate({next_acc, next_mplier}, neg);
    end
`else
    always_comb begin
        a_mag    = op_a;
        b_mag    = op_b;
        prod_fin = {next_acc, next_mplier};
    end
`endif

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .next_acc    (next_acc),
        .next_mplier (next_mplier)
    );

    assign last_step = (cnt == CNT_W'(WIDTH-1));
    assign stall_req = start | busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULTU_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef MULTU_SIGNED_EN
                        neg    <= neg_in;
`endif
                    end
                end
                ST_RUN: begin
                    acc    <= next_acc;
                    mplier <= next_mplier;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        {hi, lo} <= prod_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multu_unit.sv
module tb_multu_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
`ifdef MULTU_SIGNED_EN
    logic             is_signed = 1'b0;
`endif
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             busy, done, stall_req;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    multu_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef MULTU_SIGNED_EN
        .is_signed (is_signed),
`endif
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
        logic [WIDTH-1:0] exp_hi;
        logic [WIDTH-1:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
`ifdef MULTU_SIGNED_EN
        is_signed = sgn;
`else
        if (sgn) $display("note: signed vector skipped");
`endif
        #1;
        chk("stall_issue", {63'd0, stall_req}, 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes cycles 1..40 after issue; optionally re-raises start (9*9) at one cycle.
    task automatic observe(input int restart_at, output int busy_n, output int done_n,
                           output int done_at, output bit stall_bad, output logic [63:0] pre_done);
        busy_n = 0; done_n = 0; done_at = 0; stall_bad = 0; pre_done = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == restart_at) begin
                start = 1'b1; op_a = 32'd9; op_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            if (stall_req !== ((k <= WIDTH) ? 1'b1 : 1'b0)) stall_bad = 1;
            if (k == WIDTH) pre_done = {hi, lo};
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sgn, input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                                 input int restart_at, output logic [63:0] pre_done);
        int busy_n, done_n, done_at;
        bit stall_bad;
        issue(a, b, sgn);
        observe(restart_at, busy_n, done_n, done_at, stall_bad, pre_done);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
        chk({tag, "_done_count"}, 64'(done_n), 64'd1);
        chk({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        chk({tag, "_stall"}, {63'd0, stall_bad}, 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        logic [63:0] pre;

        vecs.push_back('{32'd3,          32'd5,          1'b0, 32'h0,        32'd15});
        vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{32'hFFFFFFFF,   32'd1,          1'b0, 32'h0,        32'hFFFFFFFF});
        vecs.push_back('{32'h00010000,   32'h00010000,   1'b0, 32'h1,        32'h0});
        vecs.push_back('{32'd0,          32'hDEADBEEF,   1'b0, 32'h0,        32'h0});
`ifdef MULTU_SIGNED_EN
        vecs.push_back('{32'hFFFFFFFD,   32'd5,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1});
        vecs.push_back('{32'hFFFFFFFD,   32'd5,          1'b0, 32'h4,        32'hFFFFFFF1});
        vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'h0,        32'h1});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven products
        for (int i = 0; i < vecs.size(); i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                          vecs[i].exp_hi, vecs[i].exp_lo, 0, pre);
        end

        // HI/LO hold until the completing edge of the next operation
        run_and_check("msb", 32'h80000000, 32'd2, 1'b0, 32'd1, 32'd0, 0, pre);
        run_and_check("hold", 32'd0, 32'd7, 1'b0, 32'd0, 32'd0, 0, pre);
        chk("hold_pre_done", pre, {32'd1, 32'd0});

        // start during RUN is ignored
        run_and_check("restart", 32'h1234, 32'h10, 1'b0, 32'd0, 32'h12340, 10, pre);

        // Asynchronous reset mid-operation
        issue(32'h12345678, 32'd9, 1'b0);
        repeat (19) @(negedge clk);
        chk("arst_busy_before", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_and_check("after_rst", 32'd6, 32'd7, 1'b0, 32'd0, 32'd42, 0, pre);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
